// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and transmitter state encoding.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit to each frame).
package mmio_uart_pkg;

    localparam logic [3:0] TXDATA_OFS = 4'h0;
    localparam logic [3:0] STATUS_OFS = 4'h8;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Memory-stage bus seen by the UART register window.
interface mmio_uart_tx_if;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        wmem;
    logic [2:0]  funct3;
    logic [63:0] rdata;
    logic        hit;

    modport master (output addr, wdata, wmem, funct3, input rdata, hit);
    modport slave  (input addr, wdata, wmem, funct3, output rdata, hit);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter. Head byte is presented combinationally;
// push while full and pop while empty are ignored.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [7:0]             data_i,
    input  logic                   pop_i,
    output logic [7:0]             data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Occupancy update for simultaneous push/pop
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage array, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS register window, TX FIFO and
// serial framing FSM (8N1, or 8E1 when UART_TX_PARITY_EN is defined).
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR    = 64'h0000_0000_1000_0000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16
) (
    input  logic          clk,
    input  logic          rst,
    mmio_uart_tx_if.slave bus,
    output logic          tx
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    logic [63:0]    offset;
    logic           in_win, store_ok, wr_txdata, wr_status;
    logic           push, pop, full, empty, overflow;
    logic [7:0]     head;
    logic [FCW-1:0] count;
    logic [7:0]     count8;
    logic [63:0]    status;
    logic           ovf_q, ovf_d;

    tx_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     data_q, data_d;
    logic           tx_q, tx_d;
    logic           bit_done;

    assign offset    = bus.addr - BASE_ADDR;
    assign in_win    = (offset < 64'd16);
    // Only store encodings (SB/SH/SW/SD, funct3[2]=0) qualify as register writes
    assign store_ok  = bus.wmem && !bus.funct3[2];
    assign wr_txdata = store_ok && in_win && (offset[3:0] == TXDATA_OFS);
    assign wr_status = store_ok && in_win && (offset[3:0] == STATUS_OFS);
    // FULL is the pre-pop value, so a write while full is lost even if a pop frees a slot
    assign push      = wr_txdata && !full;
    assign overflow  = wr_txdata && full;
    assign count8    = (32'(count) > 32'd255) ? 8'hFF : 8'(count);

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (bus.wdata[7:0]),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // STATUS assembly and read mux
    always_comb begin
        status = '0;
        status[STAT_FULL_BIT]  = full;
        status[STAT_EMPTY_BIT] = empty;
        status[STAT_BUSY_BIT]  = (state_q != ST_IDLE);
        status[STAT_OVF_BIT]   = ovf_q;
        status[STAT_COUNT_LSB +: 8] = count8;
        bus.hit   = in_win;
        bus.rdata = (in_win && offset[3:0] == STATUS_OFS) ? status : 64'd0;
        ovf_d = ovf_q;
        if (overflow)       ovf_d = 1'b1;
        else if (wr_status) ovf_d = 1'b0;
    end

    assign bit_done = (cnt_q == '0);

    // Framing FSM: next state, bit timer, bit index and serial output
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop = 1'b1; data_d = head; idx_d = '0;
                    cnt_d = CNT_LOAD; tx_d = 1'b0; state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    cnt_d = CNT_LOAD; idx_d = '0; tx_d = data_q[0]; state_d = ST_DATA;
                end else cnt_d = cnt_q - CNT_W'(1);
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_d = CNT_LOAD;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d = ^data_q; state_d = ST_PARITY;
`else
                        tx_d = 1'b1; state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1; tx_d = data_q[idx_q + 3'd1];
                    end
                end else cnt_d = cnt_q - CNT_W'(1);
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    cnt_d = CNT_LOAD; tx_d = 1'b1; state_d = ST_STOP;
                end else cnt_d = cnt_q - CNT_W'(1);
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    if (!empty) begin
                        pop = 1'b1; data_d = head; idx_d = '0;
                        cnt_d = CNT_LOAD; tx_d = 1'b0; state_d = ST_START;
                    end else begin
                        cnt_d = '0; tx_d = 1'b1; state_d = ST_IDLE;
                    end
                end else cnt_d = cnt_q - CNT_W'(1);
            end
            default: begin
                cnt_d = '0; idx_d = '0; tx_d = 1'b1; state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx = tx_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mmio_uart_tx;
    localparam logic [63:0] BASE = 64'h0000_0000_1000_0000;
    localparam int CPB = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    int checks = 0;
    int errors = 0;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic        exp_hit;
        logic [63:0] exp_rdata;
    } rd_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        bus.addr = a; bus.wdata = d; bus.wmem = 1'b1; bus.funct3 = 3'b011;
    endtask

    task automatic idle_bus();
        bus.addr = BASE + 64'h100; bus.wdata = '0; bus.wmem = 1'b0; bus.funct3 = 3'b011;
    endtask

    task automatic rd_status(input string name, input logic [63:0] exp);
        bus.addr = BASE + 64'd8; bus.wmem = 1'b0;
        #1;
        check(name, bus.rdata, exp);
    endtask

    // Samples tx once per cycle from frame cycle kstart through one idle cycle after the last frame
    task automatic check_stream(input logic [7:0] b0, input logic [7:0] b1, input int nfr, input int kstart);
        for (int k = kstart; k <= nfr * FRAME + 1; k++) begin
            logic e;
            if (k > nfr * FRAME) e = 1'b1;
            else e = frame_bit((k <= FRAME) ? b0 : b1, ((k - 1) % FRAME) / CPB);
            check($sformatf("tx cycle %0d", k), {63'd0, tx}, {63'd0, e});
            step();
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_bus();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rd_vec_t vecs[7];
        int lows;
        vecs[0] = '{BASE,                  1'b1, 64'h0};
        vecs[1] = '{BASE + 64'd8,          1'b1, 64'h2};
        vecs[2] = '{BASE + 64'd4,          1'b1, 64'h0};
        vecs[3] = '{BASE + 64'd15,         1'b1, 64'h0};
        vecs[4] = '{BASE + 64'd16,         1'b0, 64'h0};
        vecs[5] = '{BASE - 64'd1,          1'b0, 64'h0};
        vecs[6] = '{64'h0,                 1'b0, 64'h0};

        idle_bus();
        apply_reset();
        check("reset tx", {63'd0, tx}, 64'd1);

        for (int i = 0; i < 7; i++) begin
            bus.addr = vecs[i].addr; bus.wmem = 1'b0;
            #1;
            check($sformatf("vec%0d hit", i), {63'd0, bus.hit}, {63'd0, vecs[i].exp_hit});
            check($sformatf("vec%0d rdata", i), bus.rdata, vecs[i].exp_rdata);
        end

        // Write to an unmapped in-window offset is ignored
        step();
        wr(BASE + 64'd4, 64'h55);
        step();
        idle_bus();
        rd_status("ignored write status", 64'h2);
        step();
        check("ignored write tx", {63'd0, tx}, 64'd1);

        // Single frame 0x55, upper data bits ignored
        wr(BASE, 64'hFFFF_FFFF_FFFF_FF55);
        step();
        idle_bus();
        check("55 tx before start", {63'd0, tx}, 64'd1);
        rd_status("55 status queued", 64'h100);
        step();
        rd_status("55 status busy", 64'h6);
        check_stream(8'h55, 8'h00, 1, 1);
        rd_status("55 status done", 64'h2);

        // Back-to-back frames, push and pop coincide on the second write
        wr(BASE, 64'hA3);
        step();
        bus.wdata = 64'h0F;
        step();
        idle_bus();
        check_stream(8'hA3, 8'h0F, 2, 1);

        // Overflow: six consecutive writes into a depth-4 FIFO
        for (int i = 0; i < 6; i++) begin
            wr(BASE, 64'h11 + 64'(i));
            step();
        end
        idle_bus();
        rd_status("ovf status", 64'h40D);
        wr(BASE + 64'd8, 64'h0);
        step();
        idle_bus();
        rd_status("ovf cleared", 64'h405);
        wr(BASE, 64'h77);
        step();
        idle_bus();
        rd_status("ovf set again", 64'h40D);
        apply_reset();
        rd_status("status after reset", 64'h2);

        // Reset during data bit 3
        step();
        wr(BASE, 64'h55);
        step();
        idle_bus();
        repeat (18) step();
        check("tx in data bit3", {63'd0, tx}, 64'd0);
        rst = 1'b1;
        #1;
        check("tx async reset", {63'd0, tx}, 64'd1);
        step();
        step();
        rst = 1'b0;
        rd_status("status after abort", 64'h2);
        lows = 0;
        repeat (48) begin
            if (tx !== 1'b1) lows++;
            step();
        end
        check("no residual frame", 64'(lows), 64'd0);

        // First edge after reset release accepts a write
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr(BASE, 64'h81);
        step();
        idle_bus();
        rd_status("first enqueue accepted", 64'h100);
        step();
        check("first enqueue start bit", {63'd0, tx}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'h0000_0000_1000_0000, base of the 16-byte register window.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 868, clocks per serial bit (100 MHz / 115200 baud).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, TX FIFO entries, power of two, 2..256.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port addr  input  64  memory-stage address (mr).
REQ-007 SHALL have port wdata  input  64  memory-stage store data (mqb).
REQ-008 SHALL have port wmem  input  1  memory-stage write enable.
REQ-009 SHALL have port funct3  input  3  memory-stage access size; ignored except for decode qualification.
REQ-010 SHALL have port rdata  output  64  combinational read data.
REQ-011 SHALL have port hit  output  1  combinational; high when addr is inside the window, for the data-memory read mux.
REQ-012 SHALL have port tx  output  1  registered serial line, idle high.

Function
REQ-013 Register map SHALL be: BASE+0 TXDATA (write-only); BASE+8 STATUS (read; write clears OVF).
REQ-014 A cycle with wmem=1 and addr=BASE+0 SHALL enqueue wdata[7:0]; upper bits are ignored.
REQ-015 STATUS SHALL read {48'b0, count[7:0], 4'b0, OVF, BUSY, EMPTY, FULL} (bits 3..0); count saturates at FIFO_DEPTH.
REQ-016 Any other in-window address SHALL read 0 and ignore writes; out-of-window reads SHALL return 0 with hit=0.
REQ-017 FULL SHALL be evaluated before the same cycle's pop: a write while FULL is dropped even if a pop occurs that cycle, and sets sticky OVF.
REQ-018 Enqueue and pop in the same cycle while not full SHALL leave count unchanged and preserve FIFO order.
REQ-019 Transmitter FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-020 IDLE with FIFO non-empty SHALL pop the head and enter START on the same edge; tx goes low on that edge.
REQ-021 A byte written at edge E0 into an empty FIFO with FSM IDLE SHALL drive tx low at edge E0+1.
REQ-022 Each state SHALL hold for exactly CLKS_PER_BIT cycles using a down-counter reloaded on every bit boundary.
REQ-023 DATA SHALL send 8 bits LSB first via a 3-bit index; after bit 7 go to PARITY or STOP.
REQ-024 STOP SHALL drive tx high, then return to IDLE; if the FIFO is non-empty at that edge, it SHALL pop and enter START directly (back-to-back frames, no idle gap).
REQ-025 BUSY SHALL be high in every state except IDLE.
REQ-026 A write to BASE+8 SHALL clear OVF; a simultaneous overflow SHALL take priority and leave OVF=1.

Reset
REQ-027 While rst=1 and asynchronously on assertion: tx=1, FSM=IDLE, FIFO empty (count=0), OVF=0, bit counter and index=0.
REQ-028 Reset mid-frame SHALL abort the frame immediately; no partial byte resumes after release.
REQ-029 The first enqueue SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro UART_TX_PARITY_EN defined: FSM SHALL include PARITY, sending even parity (XOR of the 8 data bits); frame = 11 bits.
REQ-031 Macro undefined: PARITY state and logic SHALL be absent; frame = 10 bits (8N1).

Structure
REQ-032 Shared package mmio_uart_pkg SHALL hold register offsets (TXDATA_OFS=0, STATUS_OFS=8), STATUS bit positions and the FSM state encoding.
REQ-033 FIFO SHALL be sub-module uart_tx_fifo (parameterised depth, push/pop/full/empty/count); FSM and decode stay in mmio_uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-034 Write 0x55 to BASE+0 after reset -> tx low at next edge, then 1,0,1,0,1,0,1,0 in 4-cycle bits, then stop high; 40 cycles total (44 with parity, parity=0).
REQ-035 Write 0xA3 then 0x0F on consecutive cycles -> two frames back-to-back, no idle cycle between the stop bit and the next start bit.
REQ-036 Write 6 bytes in 6 consecutive cycles while idle -> first pops immediately, 4 stored, 6th dropped; STATUS reads FULL=1, OVF=1, count=4.
REQ-037 Write BASE+8 -> OVF=0; same-cycle write to BASE+8 and overflow write -> OVF stays 1.
REQ-038 Assert rst during DATA bit 3 -> tx=1 immediately, STATUS=0x2 (EMPTY) after release, no residual frame.
REQ-039 Read BASE+4 and BASE+16 -> rdata=0; hit=1 then hit=0.
